// File: rtl/u409_pkg.sv
// Shared constants and types for the u409 CPU cycle decoder.
// The bus-timeout feature is enabled by defining U409_BUS_TIMEOUT_EN.
package u409_pkg;

  localparam logic [15:0] AC_SPACE_ADDR  = 16'h00E8;
  localparam logic [7:0]  TIMEOUT_CYCLES = 8'd255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ABORT  = 2'd2
  } state_e;

  // One-hot cycle decode; exactly one bit is set whenever a decode is produced.
  typedef struct packed {
    logic unmapped;
    logic pro;
    logic lide;
    logic bridge;
    logic autocfg;
  } decode_t;

endpackage

// File: rtl/u409_addr_match.sv
// Combinational address decode: address A[31:16] against the autoconfig space
// and the three board bases, priority-ordered into a one-hot result.
module u409_addr_match
  import u409_pkg::*;
(
  input  logic [15:0] i_addr,
  input  logic        i_configured,
  input  logic [7:0]  i_bridge_base,
  input  logic [6:0]  i_lide_base,
  input  logic [3:0]  i_pro_base,
  output decode_t     o_decode
);

  logic w_low_16m;

  assign w_low_16m = (i_addr[15:8] == 8'h00);

  always_comb begin
    o_decode = '0;
    if (!i_configured && (i_addr == AC_SPACE_ADDR)) begin
      o_decode.autocfg = 1'b1;
    end else if (i_configured && w_low_16m && (i_addr[7:0] == i_bridge_base)) begin
      o_decode.bridge = 1'b1;
    end else if (i_configured && w_low_16m && (i_addr[7:1] == i_lide_base)) begin
      o_decode.lide = 1'b1;
    end else if (i_configured && (i_pro_base != 4'h0) && (i_addr[15:12] == i_pro_base)) begin
      o_decode.pro = 1'b1;
    end else begin
      o_decode.unmapped = 1'b1;
    end
  end

endmodule

// File: rtl/u409_cycle_decode.sv
// CPU cycle tracker: latches A[31:16] on TSn, holds a registered one-hot decode
// until TERM. With U409_BUS_TIMEOUT_EN defined, an unterminated cycle aborts via BUS_TEA.
module u409_cycle_decode
  import u409_pkg::*;
(
  input  logic        CLK40,
  input  logic        RESETn,
  input  logic        TSn,
  input  logic [15:0] A_HI,
  input  logic        TERM,
  input  logic        CONFIGURED,
  input  logic [7:0]  BRIDGE_BASE,
  input  logic [6:0]  LIDE_BASE,
  input  logic [3:0]  PRO_BASE,
  output logic        AUTOCONFIG_SPACE,
  output logic        BRIDGE_CYC,
  output logic        LIDE_CYC,
  output logic        PRO_CYC,
  output logic        UNMAPPED,
  output logic        BUS_TEA,
  output logic [1:0]  o_dbg_state
);

  // Bus protocol: TSn low in IDLE opens a cycle; TERM high in ACTIVE closes it.
  // TSn outside IDLE is ignored, and TERM outside ACTIVE is ignored.
  state_e      r_state;
  state_e      w_next_state;
  logic [15:0] r_addr;
  logic [15:0] w_match_addr;
  logic        w_load;
  decode_t     r_dec;
  decode_t     w_dec_next;
  decode_t     w_match;

  // In IDLE the incoming address is decoded so outputs are valid right after TSn is sampled.
  assign w_match_addr = (r_state == ST_IDLE) ? A_HI : r_addr;

  u409_addr_match u_addr_match (
    .i_addr        (w_match_addr),
    .i_configured  (CONFIGURED),
    .i_bridge_base (BRIDGE_BASE),
    .i_lide_base   (LIDE_BASE),
    .i_pro_base    (PRO_BASE),
    .o_decode      (w_match)
  );

`ifdef U409_BUS_TIMEOUT_EN
  logic [7:0] r_count;
  logic       r_tea;
  logic       w_tea_next;
`endif

  always_comb begin
    w_next_state = r_state;
    w_dec_next   = '0;
    w_load       = 1'b0;
`ifdef U409_BUS_TIMEOUT_EN
    w_tea_next   = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!TSn) begin
          w_next_state = ST_ACTIVE;
          w_load       = 1'b1;
          w_dec_next   = w_match;
        end
      end
      ST_ACTIVE: begin
        if (TERM) begin
          w_next_state = ST_IDLE;
`ifdef U409_BUS_TIMEOUT_EN
        end else if (r_count == TIMEOUT_CYCLES) begin
          w_next_state = ST_ABORT;
          w_tea_next   = 1'b1;
`endif
        end else begin
          w_dec_next = w_match;
        end
      end
`ifdef U409_BUS_TIMEOUT_EN
      ST_ABORT: begin
        w_next_state = ST_IDLE;
      end
`endif
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      r_state <= ST_IDLE;
      r_addr  <= '0;
      r_dec   <= '0;
    end else begin
      r_state <= w_next_state;
      r_dec   <= w_dec_next;
      if (w_load) begin
        r_addr <= A_HI;
      end
    end
  end

`ifdef U409_BUS_TIMEOUT_EN
  always_ff @(posedge CLK40) begin
    if (!RESETn) begin
      r_count <= '0;
      r_tea   <= 1'b0;
    end else begin
      r_tea <= w_tea_next;
      if (w_load) begin
        r_count <= '0;
      end else if ((r_state == ST_ACTIVE) && (r_count != 8'hFF)) begin
        r_count <= r_count + 8'd1;
      end
    end
  end

  assign BUS_TEA = r_tea;
`else
  assign BUS_TEA = 1'b0;
`endif

  assign AUTOCONFIG_SPACE = r_dec.autocfg;
  assign BRIDGE_CYC       = r_dec.bridge;
  assign LIDE_CYC         = r_dec.lide;
  assign PRO_CYC          = r_dec.pro;
  assign UNMAPPED         = r_dec.unmapped;
  assign o_dbg_state      = r_state;

endmodule

// File: tb/tb_u409_cycle_decode.sv
// Bench for u409_cycle_decode: directed scenarios with literal checks plus a
// randomized run compared every cycle against a transaction-level model.
module tb_u409_cycle_decode;

  logic        CLK40;
  logic        RESETn;
  logic        TSn;
  logic [15:0] A_HI;
  logic        TERM;
  logic        CONFIGURED;
  logic [7:0]  BRIDGE_BASE;
  logic [6:0]  LIDE_BASE;
  logic [3:0]  PRO_BASE;
  logic        AUTOCONFIG_SPACE;
  logic        BRIDGE_CYC;
  logic        LIDE_CYC;
  logic        PRO_CYC;
  logic        UNMAPPED;
  logic        BUS_TEA;
  logic [1:0]  dbg_state;

  localparam logic [5:0] E_NONE   = 6'b000000;
  localparam logic [5:0] E_AC     = 6'b000001;
  localparam logic [5:0] E_BRIDGE = 6'b000010;
  localparam logic [5:0] E_LIDE   = 6'b000100;
  localparam logic [5:0] E_PRO    = 6'b001000;
  localparam logic [5:0] E_UNM    = 6'b010000;
  localparam logic [5:0] E_TEA    = 6'b100000;

  int n_cmp  = 0;
  int n_fail = 0;

  u409_cycle_decode dut (
    .CLK40            (CLK40),
    .RESETn           (RESETn),
    .TSn              (TSn),
    .A_HI             (A_HI),
    .TERM             (TERM),
    .CONFIGURED       (CONFIGURED),
    .BRIDGE_BASE      (BRIDGE_BASE),
    .LIDE_BASE        (LIDE_BASE),
    .PRO_BASE         (PRO_BASE),
    .AUTOCONFIG_SPACE (AUTOCONFIG_SPACE),
    .BRIDGE_CYC       (BRIDGE_CYC),
    .LIDE_CYC         (LIDE_CYC),
    .PRO_CYC          (PRO_CYC),
    .UNMAPPED         (UNMAPPED),
    .BUS_TEA          (BUS_TEA),
    .o_dbg_state      (dbg_state)
  );

  // ---------------- clock ----------------
  initial CLK40 = 1'b0;
  always #5 CLK40 = ~CLK40;

  function automatic logic [5:0] dut_out();
    return {BUS_TEA, UNMAPPED, PRO_CYC, LIDE_CYC, BRIDGE_CYC, AUTOCONFIG_SPACE};
  endfunction

  // ---------------- reference model ----------------
  // Decode by address windows: 32-bit address ranges of each board.
  function automatic logic [5:0] ref_decode(input logic [15:0] a, input logic cfg,
                                            input logic [7:0] bb, input logic [6:0] lb,
                                            input logic [3:0] pb);
    longint addr, b_lo, l_lo, p_lo;
    addr = longint'(a) * 65536;
    b_lo = longint'(bb) * 65536;
    l_lo = longint'(lb) * 131072;
    p_lo = longint'(pb) * 268435456;
    if (!cfg && a == 16'h00E8)                                  return E_AC;
    if (cfg && addr >= b_lo && addr < b_lo + 65536)             return E_BRIDGE;
    if (cfg && addr >= l_lo && addr < l_lo + 131072)            return E_LIDE;
    if (cfg && pb != 0 && addr >= p_lo && addr < p_lo + 268435456) return E_PRO;
    return E_UNM;
  endfunction

  logic [5:0]  exp_q[$];
  bit          m_in_cycle = 0;
  bit          m_aborting = 0;
  int          m_age      = 0;
  logic [15:0] m_addr     = '0;
  logic [5:0]  m_exp;

  always @(posedge CLK40) begin
    m_exp = E_NONE;
    if (!RESETn) begin
      m_in_cycle = 0;
      m_aborting = 0;
      m_age      = 0;
      m_addr     = '0;
    end else if (m_aborting) begin
      m_aborting = 0;
    end else if (!m_in_cycle) begin
      if (!TSn) begin
        m_in_cycle = 1;
        m_addr     = A_HI;
        m_age      = 0;
        m_exp      = ref_decode(A_HI, CONFIGURED, BRIDGE_BASE, LIDE_BASE, PRO_BASE);
      end
    end else if (TERM) begin
      m_in_cycle = 0;
    end else begin
      m_age = m_age + 1;
`ifdef U409_BUS_TIMEOUT_EN
      if (m_age >= 256) begin
        m_in_cycle = 0;
        m_aborting = 1;
        m_exp      = E_TEA;
      end else begin
        m_exp = ref_decode(m_addr, CONFIGURED, BRIDGE_BASE, LIDE_BASE, PRO_BASE);
      end
`else
      m_exp = ref_decode(m_addr, CONFIGURED, BRIDGE_BASE, LIDE_BASE, PRO_BASE);
`endif
    end
    exp_q.push_back(m_exp);
  end

  // ---------------- scoreboard compare ----------------
  logic [5:0] sb_exp;
  always @(negedge CLK40) begin
    if (exp_q.size() > 0) begin
      sb_exp = exp_q.pop_front();
      n_cmp++;
      if (dut_out() !== sb_exp) begin
        n_fail++;
        $display("FAIL cycle_out @%0t: got %b expected %b", $time, dut_out(), sb_exp);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc();
    @(posedge CLK40);
    #2;
  endtask

  task automatic check_lit(input string name, input logic [5:0] exp);
    n_cmp++;
    if (dut_out() !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, dut_out(), exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic start_cycle(input logic [15:0] a);
    TSn  = 1'b0;
    A_HI = a;
    cyc();
    TSn  = 1'b1;
    A_HI = 16'($urandom);
  endtask

  task automatic end_cycle();
    TERM = 1'b1;
    cyc();
    TERM = 1'b0;
  endtask

  task automatic directed_access(input string name, input logic [15:0] a, input logic [5:0] exp);
    start_cycle(a);
    check_lit(name, exp);
    cyc();
    check_lit({name, "_hold"}, exp);
    end_cycle();
    check_lit({name, "_term"}, E_NONE);
  endtask

  // ---------------- main sequence ----------------
  int k;
  bit tea_seen;

  initial begin
    RESETn      = 1'b0;
    TSn         = 1'b1;
    A_HI        = '0;
    TERM        = 1'b0;
    CONFIGURED  = 1'b0;
    BRIDGE_BASE = '0;
    LIDE_BASE   = '0;
    PRO_BASE    = '0;
    repeat (3) cyc();
    check_lit("reset_state", E_NONE);
    RESETn = 1'b1;
    cyc();
    check_lit("idle_after_reset", E_NONE);

    // Autoconfig access before configuration.
    start_cycle(16'h00E8);
    check_lit("autoconfig", E_AC);
    end_cycle();
    check_lit("autoconfig_term", E_NONE);

    CONFIGURED  = 1'b1;
    BRIDGE_BASE = 8'hE9;
    LIDE_BASE   = 7'h75;
    PRO_BASE    = 4'h4;
    directed_access("bridge",   16'h00E9, E_BRIDGE);
    directed_access("lide",     16'h00EB, E_LIDE);
    directed_access("lide_lo",  16'h00EA, E_LIDE);
    directed_access("pro",      16'h4123, E_PRO);
    directed_access("unmapped", 16'h00E8, E_UNM);

    // TSn while ACTIVE is ignored.
    start_cycle(16'h00E9);
    TSn  = 1'b0;
    A_HI = 16'h4123;
    cyc();
    TSn = 1'b1;
    check_lit("ts_ignored", E_BRIDGE);
    cyc();
    check_lit("ts_ignored_hold", E_BRIDGE);
    end_cycle();
    check_lit("ts_ignored_term", E_NONE);

    // TSn and TERM together in IDLE start a new cycle.
    TERM = 1'b1;
    start_cycle(16'h4FFF);
    TERM = 1'b0;
    check_lit("ts_term_idle", E_PRO);
    end_cycle();

    // Base change mid-cycle applies on the next edge.
    start_cycle(16'h00E9);
    check_lit("base_before", E_BRIDGE);
    BRIDGE_BASE = 8'hE0;
    cyc();
    check_lit("base_changed", E_UNM);
    BRIDGE_BASE = 8'hE9;
    cyc();
    check_lit("base_restored", E_BRIDGE);
    end_cycle();

    // Reset mid-cycle, then TSn on the first cycle after release.
    start_cycle(16'h4123);
    check_lit("pro_pre_reset", E_PRO);
    RESETn = 1'b0;
    cyc();
    check_lit("mid_reset", E_NONE);
    RESETn = 1'b1;
    start_cycle(16'h00E9);
    check_lit("post_reset_decode", E_BRIDGE);
    end_cycle();

    // Unterminated cycle.
    start_cycle(16'h00E8);
    check_lit("timeout_unmapped", E_UNM);
`ifdef U409_BUS_TIMEOUT_EN
    k = 0;
    while (!BUS_TEA && k < 400) begin
      cyc();
      k++;
    end
    check_int("timeout_latency", k, 256);
    check_lit("timeout_tea", E_TEA);
    cyc();
    check_lit("timeout_idle", E_NONE);
    start_cycle(16'h00EB);
    check_lit("after_timeout", E_LIDE);
    end_cycle();
`else
    tea_seen = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc();
      if (BUS_TEA) tea_seen = 1;
    end
    check_int("no_tea_1000", int'(tea_seen), 0);
    check_lit("still_unmapped", E_UNM);
    end_cycle();
    check_lit("late_term", E_NONE);
`endif

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      RESETn = ($urandom_range(0, 249) != 0);
      TSn    = ($urandom_range(0, 3) != 0);
      TERM   = ($urandom_range(0, 5) == 0);
      case ($urandom_range(0, 5))
        0: A_HI = 16'h00E8;
        1: A_HI = 16'h00E9;
        2: A_HI = {8'h00, 7'h75, 1'($urandom)};
        3: A_HI = {4'h4, 12'($urandom)};
        4: A_HI = {8'h00, 8'($urandom)};
        default: A_HI = 16'($urandom);
      endcase
      if ($urandom_range(0, 19) == 0) CONFIGURED = ~CONFIGURED;
      if ($urandom_range(0, 49) == 0) BRIDGE_BASE = 8'($urandom_range(8'hE0, 8'hEF));
      if ($urandom_range(0, 49) == 0) LIDE_BASE = 7'($urandom_range(7'h70, 7'h77));
      if ($urandom_range(0, 49) == 0) PRO_BASE = 4'($urandom_range(0, 5));
      cyc();
    end

    RESETn = 1'b1;
    TSn    = 1'b1;
    TERM   = 1'b1;
    repeat (3) cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/u409_cycle_decode.md
U409_CYCLE_DECODE -- requirements
Module: u409_cycle_decode

Interface
REQ-001 SHALL have ports: CLK40  in  1  system clock, all logic on rising edge.
REQ-002 SHALL have port: RESETn  in  1  reset, synchronous, active-low.
REQ-003 SHALL have port: TSn  in  1  CPU transfer start, active-low.
REQ-004 SHALL have port: A_HI  in  16  CPU address A[31:16].
REQ-005 SHALL have port: TERM  in  1  any cycle termination seen (target TA or AC_TACK), active-high.
REQ-006 SHALL have port: CONFIGURED  in  1  autoconfig chain complete.
REQ-007 SHALL have ports: BRIDGE_BASE in 8 (A[23:16]); LIDE_BASE in 7 (A[23:17]); PRO_BASE in 4 (A[31:28]).
REQ-008 SHALL have outputs, 1 bit each: AUTOCONFIG_SPACE, BRIDGE_CYC, LIDE_CYC, PRO_CYC, UNMAPPED, BUS_TEA.

Function
REQ-009 SHALL implement states IDLE, ACTIVE, ABORT.
REQ-010 IDLE: TSn=0 sampled -> latch A_HI, register the decode, go ACTIVE; decode outputs valid on the next edge.
REQ-011 Decode, priority order, exactly one output high in ACTIVE:
  - AUTOCONFIG_SPACE: A_HI=16'h00E8 and CONFIGURED=0.
  - BRIDGE_CYC: CONFIGURED=1, A_HI[31:24]=0, A_HI[23:16]=BRIDGE_BASE (64K).
  - LIDE_CYC: CONFIGURED=1, A_HI[31:24]=0, A_HI[23:17]=LIDE_BASE (128K).
  - PRO_CYC: CONFIGURED=1, A_HI[31:28]=PRO_BASE, PRO_BASE!=0 (256MB).
  - UNMAPPED: none of the above.
REQ-012 ACTIVE: TERM=1 sampled -> clear all decode outputs on that edge, go IDLE.
REQ-013 TSn=0 while ACTIVE or ABORT SHALL be ignored; the latched address is not updated.
REQ-014 TSn=0 and TERM=1 on the same edge in IDLE: TERM ignored, new cycle starts.
REQ-015 Base inputs SHALL be compared against the latched address every cycle; base changes mid-cycle take effect next edge.
REQ-016 Cycle counter, 8-bit, SHALL clear on entry to ACTIVE, increment each ACTIVE cycle, saturate at 255.
REQ-017 Decode outputs, BUS_TEA SHALL be glitch-free registered outputs.

Reset
REQ-018 RESETn=0 sampled SHALL force IDLE, counter 0, latched address 0, all outputs 0, regardless of state, including mid-cycle.
REQ-019 First cycle after reset release SHALL honour TSn=0 normally.

Configuration
REQ-020 Macro U409_BUS_TIMEOUT_EN defined: ACTIVE with counter=TIMEOUT_CYCLES (255) and TERM=0 -> clear decode outputs, BUS_TEA=1 for exactly one cycle (ABORT), then IDLE.
REQ-021 Macro not defined: no ABORT state, BUS_TEA tied 0, counter omitted, ACTIVE waits for TERM indefinitely.

Structure
REQ-022 Shared package u409_pkg SHALL hold: AC_SPACE_ADDR (16'h00E8), TIMEOUT_CYCLES (8'd255), state encoding constants.
REQ-023 Single sub-module u409_addr_match: combinational compare of latched address vs bases, producing the one-hot decode; FSM and counter in the parent.

Verification
REQ-024 Reset, CONFIGURED=0, TSn=0 with A_HI=16'h00E8 -> AUTOCONFIG_SPACE=1 next edge; TERM=1 -> 0 next edge.
REQ-025 CONFIGURED=1, BRIDGE_BASE=8'hE9, LIDE_BASE=7'h75 (A=$EA), PRO_BASE=4'h4; accesses:
  - A_HI=16'h00E9 -> BRIDGE_CYC.
  - A_HI=16'h00EB -> LIDE_CYC.
  - A_HI=16'h4123 -> PRO_CYC.
  - A_HI=16'h00E8 -> UNMAPPED.
REQ-026 TSn=0 pulse while ACTIVE with a different A_HI -> outputs unchanged until TERM.
REQ-027 Macro defined, UNMAPPED cycle, no TERM -> BUS_TEA=1 for one cycle 256 cycles after decode, then IDLE; macro undefined -> BUS_TEA stays 0 for 1000 cycles.
REQ-028 RESETn=0 mid-ACTIVE PRO_CYC -> all outputs 0 next edge; TSn=0 first cycle after release decodes normally.
